// File: rtl/conv_layer_scheduler_if.sv
// Weight SRAM read port and conv engine handshake, as seen from the layer scheduler.
interface conv_layer_scheduler_if #(
    parameter int weight_bits = 3,
    parameter int addr_bits   = 9
);
    logic                   weight_rd_en;
    logic [addr_bits-1:0]   weight_rd_addr;
    logic [weight_bits-1:0] weight_rd_data;
    logic                   weight_data_valid;
    logic [weight_bits-1:0] weight_data;
    logic                   conv_start;
    logic                   conv_finish;
    logic                   conv_result_valid;

    modport master (
        output weight_rd_en, weight_rd_addr, weight_data_valid, weight_data, conv_start,
        input  weight_rd_data, conv_finish, conv_result_valid
    );

    modport slave (
        input  weight_rd_en, weight_rd_addr, weight_data_valid, weight_data, conv_start,
        output weight_rd_data, conv_finish, conv_result_valid
    );
endinterface

// File: rtl/conv_layer_scheduler.sv
// Walks every kernel of one conv layer: loads its weights from SRAM into the engine,
// runs the engine until conv_finish and flags kernels with a wrong result count.
module conv_layer_scheduler #(
    parameter int weight_bits   = 3,
    parameter int kernel_size   = 5,
    parameter int pic_size      = 28,
    parameter int kernel_number = 4,
    parameter int channel       = 3,
    localparam int WPK = kernel_size * kernel_size * channel,
    localparam int WA  = $clog2(kernel_number * WPK),
    localparam int OUT = pic_size - kernel_size + 1,
    localparam int KW  = (kernel_number > 1) ? $clog2(kernel_number) : 1,
    localparam int RC  = $clog2(pic_size * pic_size + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          layer_start,
    input  logic          layer_abort,
    output logic          layer_busy,
    output logic          layer_done,
    output logic [KW-1:0] kernel_idx,
    output logic          err_result,
    conv_layer_scheduler_if.master bus
);

    localparam int IW = (WPK > 1) ? $clog2(WPK) : 1;
    localparam logic [IW-1:0] LAST_I  = IW'(WPK - 1);
    localparam logic [KW-1:0] LAST_K  = KW'(kernel_number - 1);
    localparam logic [RC-1:0] RES_MAX = '1;
    localparam logic [RC-1:0] RES_EXP = RC'(OUT * OUT);

    typedef enum logic [2:0] {IDLE, LOAD_W, DRAIN, RUN, NEXT, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   rd_cnt;
    logic [RC-1:0]   result_cnt;
    logic [RC-1:0]   next_cnt;
    logic            rd_en;
    logic [WA-1:0]   rd_addr;
    logic            data_valid;
    logic            conv_start;

    assign layer_busy            = (state != IDLE);
    assign bus.weight_rd_en      = rd_en;
    assign bus.weight_rd_addr    = rd_addr;
    assign bus.weight_data_valid = data_valid;
    assign bus.weight_data       = data_valid ? bus.weight_rd_data : '0;
    assign bus.conv_start        = conv_start;

    // Result count including a valid that arrives together with conv_finish.
    always_comb begin
        next_cnt = result_cnt;
        if (bus.conv_result_valid && result_cnt != RES_MAX) begin
            next_cnt = result_cnt + RC'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_cnt     <= '0;
            result_cnt <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            data_valid <= 1'b0;
            conv_start <= 1'b0;
            layer_done <= 1'b0;
            kernel_idx <= '0;
            err_result <= 1'b0;
        end else if (state != IDLE && layer_abort) begin
            // Abort drops the read that is still in flight instead of forwarding it.
            state      <= IDLE;
            rd_en      <= 1'b0;
            data_valid <= 1'b0;
            conv_start <= 1'b0;
            layer_done <= 1'b0;
        end else begin
            data_valid <= rd_en;
            layer_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (layer_start) begin
                        state      <= LOAD_W;
                        kernel_idx <= '0;
                        err_result <= 1'b0;
                        result_cnt <= '0;
                        rd_cnt     <= '0;
                        rd_addr    <= '0;
                        rd_en      <= 1'b1;
                    end
                end
                LOAD_W: begin
                    if (rd_cnt == LAST_I) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd_cnt  <= rd_cnt + IW'(1);
                        rd_addr <= rd_addr + WA'(1);
                    end
                end
                DRAIN: begin
                    state      <= RUN;
                    conv_start <= 1'b1;
                end
                RUN: begin
                    result_cnt <= next_cnt;
                    if (bus.conv_finish) begin
                        conv_start <= 1'b0;
                        if (next_cnt != RES_EXP) begin
                            err_result <= 1'b1;
                        end
                        if (kernel_idx == LAST_K) begin
                            state      <= DONE;
                            layer_done <= 1'b1;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    // Kernels sit back to back in SRAM, so the address simply continues.
                    kernel_idx <= kernel_idx + KW'(1);
                    result_cnt <= '0;
                    rd_cnt     <= '0;
                    rd_addr    <= rd_addr + WA'(1);
                    rd_en      <= 1'b1;
                    state      <= LOAD_W;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Randomized scoreboard bench for conv_layer_scheduler with SRAM and conv engine models.
module tb_conv_layer_scheduler;

    localparam int K       = 4;
    localparam int WPK     = 75;
    localparam int N_EXP   = 576;
    localparam int RES_SAT = 1023;

    typedef struct {
        int k;
        bit err;
    } start_rec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       layer_start;
    logic       layer_abort;
    logic       layer_busy;
    logic       layer_done;
    logic [1:0] kernel_idx;
    logic       err_result;
    logic       eng_valid;
    logic       eng_finish;
    logic       stray_valid;
    logic       stray_finish;
    logic       mon_en;

    int         checks = 0;
    int         errors = 0;
    int         plan[K];
    logic [2:0] mem[K*WPK];

    int         addr_q[$];
    logic [2:0] data_q[$];
    start_rec_t start_q[$];
    bit         done_q[$];

    always #5 clk = ~clk;

    conv_layer_scheduler_if #(.weight_bits(3), .addr_bits(9)) bus ();

    conv_layer_scheduler #(
        .weight_bits(3), .kernel_size(5), .pic_size(28), .kernel_number(K), .channel(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .layer_start(layer_start),
        .layer_abort(layer_abort),
        .layer_busy(layer_busy),
        .layer_done(layer_done),
        .kernel_idx(kernel_idx),
        .err_result(err_result),
        .bus(bus)
    );

    assign bus.conv_finish       = eng_finish | stray_finish;
    assign bus.conv_result_valid = eng_valid | stray_valid;

    // Weight SRAM: one-cycle read latency, garbage on the bus when not reading.
    always @(posedge clk) begin
        if (bus.weight_rd_en) bus.weight_rd_data <= mem[bus.weight_rd_addr];
        else                  bus.weight_rd_data <= 3'($urandom);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] outVec();
        return 32'({layer_busy, layer_done, bus.weight_rd_en, bus.weight_rd_addr,
                    bus.weight_data_valid, bus.weight_data, bus.conv_start, kernel_idx, err_result});
    endfunction

    function automatic bit kernelBad(input int n);
        int c;
        c = (n > RES_SAT) ? RES_SAT : n;
        return (c != N_EXP);
    endfunction

    function automatic int pickCount();
        case ($urandom_range(0, 3))
            0:       return 576;
            1:       return 575;
            2:       return 577;
            default: return 100;
        endcase
    endfunction

    task automatic flushCheck();
        checkOutput("pending_reads", 32'(addr_q.size()), 0);
        checkOutput("pending_data", 32'(data_q.size()), 0);
        checkOutput("pending_runs", 32'(start_q.size()), 0);
        checkOutput("pending_done", 32'(done_q.size()), 0);
        addr_q.delete();
        data_q.delete();
        start_q.delete();
        done_q.delete();
    endtask

    // Engine model: streams plan[kernel] results with random gaps, then finishes.
    initial begin : engine
        int n;
        int sent;
        int guard;
        bit fin_last;
        eng_valid  = 1'b0;
        eng_finish = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.conv_start === 1'b1) begin
                n        = plan[kernel_idx];
                sent     = 0;
                guard    = 0;
                fin_last = 1'($urandom_range(0, 1));
                while (sent < n && bus.conv_start && guard < 5000) begin
                    eng_valid  = ($urandom_range(0, 7) != 0);
                    if (eng_valid) sent++;
                    eng_finish = fin_last && (sent == n) && eng_valid;
                    @(posedge clk); #1;
                    eng_valid  = 1'b0;
                    eng_finish = 1'b0;
                    guard++;
                end
                if (!fin_last && bus.conv_start) begin
                    eng_finish = 1'b1;
                    @(posedge clk); #1;
                    eng_finish = 1'b0;
                end
                while (bus.conv_start && guard < 6000) begin
                    @(posedge clk); #1;
                    guard++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a read, a weight, a run or a done.
    initial begin : monitor
        bit         prev_start;
        start_rec_t sr;
        bit         de;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.weight_rd_en) begin
                    if (addr_q.size() == 0) checkOutput("read_expected", 0, 1);
                    else checkOutput("read_addr", 32'(bus.weight_rd_addr), 32'(addr_q.pop_front()));
                end
                if (bus.weight_data_valid) begin
                    if (data_q.size() == 0) checkOutput("weight_expected", 0, 1);
                    else checkOutput("weight_data", 32'(bus.weight_data), 32'(data_q.pop_front()));
                end
                if (bus.conv_start && !prev_start) begin
                    if (start_q.size() == 0) checkOutput("run_expected", 0, 1);
                    else begin
                        sr = start_q.pop_front();
                        checkOutput("run_kernel", 32'(kernel_idx), 32'(sr.k));
                        checkOutput("err_at_run", 32'(err_result), 32'(sr.err));
                    end
                end
                if (layer_done) begin
                    if (done_q.size() == 0) checkOutput("done_expected", 0, 1);
                    else begin
                        de = done_q.pop_front();
                        checkOutput("done_err", 32'(err_result), 32'(de));
                        checkOutput("done_kernel", 32'(kernel_idx), 32'(K - 1));
                    end
                end
            end
            prev_start = bus.conv_start;
        end
    end

    // Runs one layer with the current plan; abort_k >= 0 aborts during that kernel's run.
    task automatic applyStimulus(input int abort_k, input bit abort_fin, input bit extras);
        int  last_k;
        bit  err_acc;
        bit  err_abort;
        bit  seen;
        last_k    = (abort_k >= 0) ? abort_k : K - 1;
        err_acc   = 1'b0;
        err_abort = 1'b0;
        seen      = 1'b0;
        for (int k = 0; k <= last_k; k++) begin
            start_q.push_back('{k: k, err: err_acc});
            for (int i = 0; i < WPK; i++) begin
                addr_q.push_back(k * WPK + i);
                data_q.push_back(mem[k * WPK + i]);
            end
            if (k == abort_k) err_abort = err_acc;
            if (kernelBad(plan[k])) err_acc = 1'b1;
        end
        if (abort_k < 0) done_q.push_back(err_acc);

        @(posedge clk); #1 layer_start = 1'b1;
        @(posedge clk); #1 layer_start = 1'b0;
        if (extras) begin
            repeat ($urandom_range(3, 30)) @(posedge clk);
            #1 layer_start = 1'b1;
            @(posedge clk); #1 layer_start = 1'b0;
            repeat ($urandom_range(3, 20)) @(posedge clk);
            #1 stray_valid = 1'b1; stray_finish = 1'b1;
            @(posedge clk); #1 stray_valid = 1'b0; stray_finish = 1'b0;
        end

        if (abort_k >= 0) begin
            for (int c = 0; c < 20000 && !seen; c++) begin
                @(negedge clk);
                if (bus.conv_start && kernel_idx == 2'(abort_k)) seen = 1'b1;
            end
            if (!seen) checkOutput("abort_timeout", 1, 0);
            repeat ($urandom_range(2, 40)) @(posedge clk);
            #1 layer_abort = 1'b1;
            stray_finish = abort_fin;
            @(posedge clk); #1 layer_abort = 1'b0; stray_finish = 1'b0;
            @(negedge clk);
            checkOutput("abort_busy", 32'(layer_busy), 0);
            checkOutput("abort_conv_start", 32'(bus.conv_start), 0);
            checkOutput("abort_rd_en", 32'(bus.weight_rd_en), 0);
            checkOutput("abort_err", 32'(err_result), 32'(err_abort));
            repeat (5) @(negedge clk);
        end else begin
            for (int c = 0; c < 20000 && !seen; c++) begin
                @(negedge clk);
                if (layer_done) seen = 1'b1;
            end
            if (!seen) checkOutput("layer_timeout", 1, 0);
            repeat (3) @(negedge clk);
            checkOutput("idle_after_done", 32'(layer_busy), 0);
            checkOutput("err_hold", 32'(err_result), 32'(err_acc));
        end
        flushCheck();
    endtask

    initial begin : watchdog
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        rst_n        = 1'b0;
        layer_start  = 1'b0;
        layer_abort  = 1'b0;
        stray_valid  = 1'b0;
        stray_finish = 1'b0;
        mon_en       = 1'b0;
        for (int i = 0; i < K * WPK; i++) mem[i] = 3'($urandom);
        for (int k = 0; k < K; k++) plan[k] = N_EXP;

        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", outVec(), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle_outputs", outVec(), 0);
        end
        @(posedge clk); #1 mon_en = 1'b1;

        $display("[TB] nominal layer");
        applyStimulus(-1, 1'b0, 1'b0);

        $display("[TB] short kernel 2");
        plan = '{576, 576, 575, 576};
        applyStimulus(-1, 1'b0, 1'b0);

        $display("[TB] abort during kernel 1 run, then restart");
        plan = '{576, 576, 576, 576};
        applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(-1, 1'b0, 1'b0);

        $display("[TB] ignored start and strays while loading, abort with finish");
        for (int k = 0; k < K; k++) plan[k] = pickCount();
        applyStimulus(-1, 1'b0, 1'b1);
        plan = '{300, 576, 576, 576};
        applyStimulus(0, 1'b1, 1'b1);

        $display("[TB] result counter saturation");
        plan = '{576, 1600, 576, 576};
        applyStimulus(-1, 1'b0, 1'b0);

        $display("[TB] random layers");
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < K; k++) plan[k] = pickCount();
            applyStimulus(-1, 1'b0, 1'b1);
        end

        $display("[TB] asynchronous reset mid-layer");
        plan = '{576, 576, 576, 576};
        mon_en = 1'b0;
        @(posedge clk); #1 layer_start = 1'b1;
        @(posedge clk); #1 layer_start = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_busy", 32'(layer_busy), 0);
        checkOutput("async_reset_rd_en", 32'(bus.weight_rd_en), 0);
        @(negedge clk);
        checkOutput("reset_outputs_mid", outVec(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1 mon_en = 1'b1;
        applyStimulus(-1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
